// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with waitrequest stalls, halt and stall timeout.
// Optional performance counters are built when MIPS_CPU_SEQ_PERF_EN is defined.
module mips_cpu_state_sequencer #(
    parameter int STALL_TIMEOUT = 0,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        pc_is_zero,
    input  logic        instr_is_load,
    input  logic        instr_is_store,
    input  logic        instr_writes_rd,
    output logic [2:0]  state,
    output logic        ir_enable,
    output logic        pc_enable,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        active,
    output logic        fault
`ifdef MIPS_CPU_SEQ_PERF_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam bit               TIMEOUT_EN  = (STALL_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               fault_q, fault_d;
    logic               mem_load_q, mem_load_d;

    logic [CNT_W-1:0]   stall_inc;
    logic               timeout_hit;

    // Saturating increment so a long stall with the timeout disabled never wraps.
    assign stall_inc   = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
    assign timeout_hit = TIMEOUT_EN && waitrequest && (stall_cnt_q == TIMEOUT_VAL);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = '0;
        fault_d     = fault_q;
        mem_load_d  = mem_load_q;
        ir_enable   = 1'b0;
        pc_enable   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (pc_is_zero) begin
                    state_d = S_HALT;
                end else if (waitrequest) begin
                    if (timeout_hit) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        mem_read    = 1'b1;
                        stall_cnt_d = stall_inc;
                    end
                end else begin
                    mem_read  = 1'b1;
                    ir_enable = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Load wins when decode flags both load and store.
                if (instr_is_load || instr_is_store) begin
                    state_d    = S_MEM;
                    mem_load_d = instr_is_load;
                end else if (instr_writes_rd) begin
                    state_d = S_WB;
                end else begin
                    pc_enable = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM: begin
                if (waitrequest) begin
                    if (timeout_hit) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        mem_read    = mem_load_q;
                        mem_write   = !mem_load_q;
                        stall_cnt_d = stall_inc;
                    end
                end else begin
                    mem_read  = mem_load_q;
                    mem_write = !mem_load_q;
                    if (mem_load_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_enable = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_enable = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts any transfer in the same cycle it is seen.
        if (reset) begin
            ir_enable = 1'b0;
            pc_enable = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            stall_cnt_q <= '0;
            fault_q     <= 1'b0;
            mem_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            fault_q     <= fault_d;
            mem_load_q  <= mem_load_d;
        end
    end

    assign state  = state_q;
    assign active = reset || (state_q != S_HALT);
    assign fault  = fault_q;

`ifdef MIPS_CPU_SEQ_PERF_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pc_enable) begin
                retired_q <= retired_q + 32'd1;
            end
            if (waitrequest && (state_q == S_FETCH || state_q == S_MEM)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Bench for mips_cpu_state_sequencer: each instruction is expanded into an expected per-cycle trace
// built from its kind and wait counts, then replayed against the DUT with random don't-care inputs.
module tb_mips_cpu_state_sequencer;

    localparam int TO = 4;

    localparam logic [5:0] ACT = 6'b000001;
    localparam logic [5:0] RW  = 6'b000010;
    localparam logic [5:0] MW  = 6'b000100;
    localparam logic [5:0] MR  = 6'b001000;
    localparam logic [5:0] PC  = 6'b010000;
    localparam logic [5:0] IR  = 6'b100000;

    localparam int K_ALU = 0, K_ALUWB = 1, K_LOAD = 2, K_STORE = 3, K_BOTH = 4;

    logic clk = 1'b0;
    logic reset, waitrequest, pc_is_zero, instr_is_load, instr_is_store, instr_writes_rd;
    logic [2:0] state;
    logic ir_enable, pc_enable, mem_read, mem_write, reg_write, active, fault;
`ifdef MIPS_CPU_SEQ_PERF_EN
    logic [31:0] retired_count, stall_count;
`endif

    mips_cpu_state_sequencer #(.STALL_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .waitrequest     (waitrequest),
        .pc_is_zero      (pc_is_zero),
        .instr_is_load   (instr_is_load),
        .instr_is_store  (instr_is_store),
        .instr_writes_rd (instr_writes_rd),
        .state           (state),
        .ir_enable       (ir_enable),
        .pc_enable       (pc_enable),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .active          (active),
        .fault           (fault)
`ifdef MIPS_CPU_SEQ_PERF_EN
        ,
        .retired_count   (retired_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         wr;
        bit         tmo;
        int         st;     // -1: state not checked
        logic [5:0] strb;   // {ir, pc, mr, mw, rw, active}
    } ent_t;

    ent_t        tr[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        fault_exp = 1'b0;
    int unsigned ret_exp = 0;
    int unsigned stl_exp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void push(input bit rst, input bit wr, input int st, input bit tmo,
                                 input logic [5:0] s);
        ent_t e;
        e.rst = rst; e.wr = wr; e.st = st; e.tmo = tmo; e.strb = s;
        tr.push_back(e);
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Expand one instruction into its expected cycle trace.
    function automatic void build(input int kind, input int fw, input int mwt, input bit pcz,
                                  input bit abort_mem, input int halt_len);
        bit halt = 1'b0;
        bit is_ld;
        tr.delete();
        if (pcz) begin
            push(0, rb(), 0, 0, ACT);
            halt = 1'b1;
        end else begin
            for (int i = 0; i <= fw && !halt; i++) begin
                if (i < fw) begin
                    if (i == TO) begin push(0, 1, 0, 1, ACT); halt = 1'b1; end
                    else push(0, 1, 0, 0, MR | ACT);
                end else begin
                    push(0, 0, 0, 0, IR | MR | ACT);
                end
            end
        end
        if (!halt) begin
            push(0, rb(), 2, 0, ACT);
            if (kind == K_ALU) begin
                push(0, rb(), 3, 0, PC | ACT);
            end else if (kind == K_ALUWB) begin
                push(0, rb(), 3, 0, ACT);
                push(0, rb(), 5, 0, RW | PC | ACT);
            end else begin
                is_ld = (kind != K_STORE);
                push(0, rb(), 3, 0, ACT);
                if (abort_mem) begin
                    push(1, rb(), -1, 0, ACT);
                    return;
                end
                for (int i = 0; i <= mwt && !halt; i++) begin
                    if (i < mwt) begin
                        if (i == TO) begin push(0, 1, 4, 1, ACT); halt = 1'b1; end
                        else push(0, 1, 4, 0, (is_ld ? MR : MW) | ACT);
                    end else begin
                        push(0, 0, 4, 0, (is_ld ? MR : (MW | PC)) | ACT);
                    end
                end
                if (!halt && is_ld) push(0, rb(), 5, 0, RW | PC | ACT);
            end
        end
        if (halt) begin
            for (int i = 0; i < halt_len; i++) push(0, rb(), 6, 0, 6'b0);
            push(1, rb(), -1, 0, ACT);
        end
    endfunction

    task automatic run(input int kind, input bit pcz);
        foreach (tr[k]) begin
            #1;
            reset           = tr[k].rst;
            waitrequest     = tr[k].wr;
            pc_is_zero      = pcz;
            instr_is_load   = (kind == K_LOAD) || (kind == K_BOTH);
            instr_is_store  = (kind == K_STORE) || (kind == K_BOTH);
            instr_writes_rd = (kind == K_ALUWB) ? 1'b1 : rb();
            if (kind == K_ALU) instr_writes_rd = 1'b0;
            @(negedge clk);
            if (tr[k].st >= 0) check("state", 32'(state), tr[k].st);
            check("strobes", 32'({ir_enable, pc_enable, mem_read, mem_write, reg_write, active}),
                  32'(tr[k].strb));
            if (!tr[k].rst) begin
                check("fault", 32'(fault), 32'(fault_exp));
`ifdef MIPS_CPU_SEQ_PERF_EN
                check("retired_count", retired_count, ret_exp);
                check("stall_count", stall_count, stl_exp);
`endif
            end
            if (tr[k].rst) begin
                fault_exp = 1'b0;
                ret_exp   = 0;
                stl_exp   = 0;
            end else begin
                if (tr[k].strb[4]) ret_exp++;
                if ((tr[k].st == 0 || tr[k].st == 4) && tr[k].wr) stl_exp++;
                if (tr[k].tmo) fault_exp = 1'b1;
            end
            @(posedge clk);
        end
    endtask

    task automatic do_instr(input int kind, input int fw, input int mwt, input bit pcz,
                            input bit abort_mem, input int halt_len);
        build(kind, fw, mwt, pcz, abort_mem, halt_len);
        run(kind, pcz);
    endtask

    initial begin
        int kind, fw, mwt, hl;
        bit pcz, ab;
        reset = 1'b1; waitrequest = 1'b0; pc_is_zero = 1'b0;
        instr_is_load = 1'b0; instr_is_store = 1'b0; instr_writes_rd = 1'b0;
        @(posedge clk);
        tr.delete();
        push(1, 0, -1, 0, ACT);
        push(1, 0, -1, 0, ACT);
        run(K_ALU, 1'b0);

        do_instr(K_ALUWB, 0, 0, 0, 0, 0);   // states 0,2,3,5
        do_instr(K_LOAD,  3, 2, 0, 0, 0);   // 10 cycles
        do_instr(K_STORE, 0, 0, 0, 0, 0);
        do_instr(K_BOTH,  1, 1, 0, 0, 0);
        do_instr(K_ALU,   0, 0, 0, 0, 0);
        do_instr(K_ALU,   0, 0, 1, 0, 20);  // pc_is_zero halt held 20 cycles
        do_instr(K_LOAD,  6, 0, 0, 0, 5);   // fetch stall timeout
        do_instr(K_STORE, 0, 7, 0, 0, 3);   // mem stall timeout
        do_instr(K_LOAD,  1, 3, 0, 1, 0);   // reset during MEM
        do_instr(K_STORE, 2, 4, 0, 0, 0);   // stall one short of timeout

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 4));
            fw   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            mwt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            pcz  = ($urandom_range(0, 14) == 0);
            ab   = ($urandom_range(0, 11) == 0);
            hl   = int'($urandom_range(1, 6));
            do_instr(kind, fw, mwt, pcz, ab, hl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
